fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch front end and producer side of the decode interface.
- Issues word reads to instruction memory and buffers returned instructions with their PC in a small in-order queue.
- Presents instr/opcode to the decode stage under a valid/ready handshake.
- Consumes taken-branch/jump redirects from decode/execute, flushing stale work.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- ADDR_W, 9, instruction-memory word-address width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  read request; memory accepts it in the cycle it is high
- imem_addr  out  ADDR_W  word address = pc[ADDR_W+1:2]
- imem_rvalid  in  1  read data valid (≥1 cycle after req, in order)
- imem_rdata  in  32  instruction word
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- instr_pc  out  32  head PC
- opcode  out  7  instr[6:0]
- redirect_valid  in  1  taken branch/jal/jalr this cycle
- redirect_pc  in  32  target PC
- fetch_misaligned  out  1  only with MISALIGN_TRAP_EN, else tied 0

Behaviour:
- Reset values:
  - pc=RESET_PC, queue empty, epoch=0, state FETCH.
  - imem_req=0, instr_valid=0, instr/instr_pc=0, fetch_misaligned=0.
- At most one outstanding memory request.
- FSM:
  - FETCH: imem_req=1 when count<DEPTH and no redirect this cycle.
    - On issue: pc+=4, tag request with current epoch, go WAIT_RSP.
  - WAIT_RSP: imem_req=0.
    - On imem_rvalid: if tag==epoch, push {issued pc, rdata}; else drop. Go FETCH.
    - Back-to-back: a response and a new request may occur in the same cycle only via FETCH next cycle, so the request rate is one per 2 cycles minimum.
  - TRAP: see Optional Feature.
- Queue:
  - Circular buffer with rd/wr pointers and a count of DEPTH+1 values.
  - Pop when instr_valid && instr_ready.
  - Push only if a slot was reserved, so it never overflows. Simultaneous push+pop keeps count unchanged.
  - Pointers wrap modulo DEPTH.
- Outputs: instr_valid = count!=0; instr/instr_pc/opcode reflect the head combinationally from registered storage. Data is undefined-but-stable when empty; the bench must not check it.
- Redirect (highest priority, single cycle):
  - Effects: count←0, pointers←0, pc←redirect_pc, epoch toggles. Any pop or push that cycle is ignored.
  - If in WAIT_RSP, stay there; the stale response is dropped by epoch mismatch.
  - instr_valid=0 the cycle after redirect.
- Latency: redirect at cycle N (FETCH, no outstanding) gives imem_req at N+1 with the target address. Earliest rvalid is N+2; instr_valid=1 at N+3.
- Redirect in the same cycle as imem_rvalid: the response is discarded (old epoch).
- Reset mid-operation clears everything asynchronously; a response arriving after reset release is dropped because the FSM is in FETCH, not WAIT_RSP.
- pc wraps modulo 2^32; imem_addr ignores pc[1:0].

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - redirect with redirect_pc[1:0]!=0 flushes as normal, sets fetch_misaligned=1 (registered, next cycle) and enters TRAP.
  - TRAP issues no requests; an in-flight response is dropped.
  - An aligned redirect clears the flag and resumes FETCH; a misaligned one stays in TRAP.
- Undefined: redirect_pc[1:0] ignored (forced to 0), no TRAP state, fetch_misaligned=0.

Decomposition:
- Shared package fetch_pkg: state enum {FETCH, WAIT_RSP, TRAP}, queue-entry struct {pc[31:0], instr[31:0]}, constant INSTR_BYTES=4.
- One sub-module natural: fetch_fifo (parameterised DEPTH circular buffer with push/pop/flush, count, head data). The FSM, pc and epoch stay in the top.

Test Plan:
- Reset release, memory latency 1, instr_ready=1: requests at addr 0,1,2,…; instr_pc 0x0,0x4,0x8 in order; opcode equals rdata[6:0].
- instr_ready=0 with DEPTH=4: exactly 4 entries are pushed, imem_req stays 0, no loss. On release, 4 pops in order, then fetching resumes.
- Redirect to 0x100 while a response is outstanding (latency 3): the stale word is never presented; the first valid instr_pc is 0x100.
- Redirect in the same cycle as imem_rvalid and a pop: queue empty next cycle, instr_valid=0, next imem_addr=0x40 for redirect_pc=0x100.
- Simultaneous push+pop at count=DEPTH-1 and across pointer wrap: count is stable and order is preserved over 20 instructions.
- With MISALIGN_TRAP_EN, redirect_pc=0x102: fetch_misaligned=1 and no imem_req. A following redirect to 0x200 clears the flag, and instr_pc=0x200 is delivered.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types for the fetch_queue front end               |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    TRAP     = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam int INSTR_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue_if : imem, decode and redirect signals of fetch_queue    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
interface fetch_queue_if #(
  parameter int ADDR_W = 9
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic [6:0]        opcode;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fetch_misaligned;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, fetch_misaligned,
    input  imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, fetch_misaligned,
    output imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : in-order circular buffer of {pc, instr} with flush      |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  entry_t                push_data,
  input  logic                  pop,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                head
);
  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Producer only pushes into a slot it reserved, so no full check here
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : instruction fetch FSM, pc/epoch tracking, decode queue |
// | Optional    : MISALIGN_TRAP_EN enables the misaligned-target trap    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   issued_pc_q, issued_pc_d;
  logic          epoch_q, epoch_d;
  logic          tag_q, tag_d;
  logic [CW-1:0] count;
  entry_t        head;
  entry_t        push_data;
  logic          issue;
  logic          push;
  logic [31:0]   target_pc;

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  logic target_misaligned;
  assign target_pc         = bus.redirect_pc;
  assign target_misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = bus.redirect_pc[1:0];
  assign target_pc            = {bus.redirect_pc[31:2], 2'b00};
`endif

  // Gated by reset so no request is presented while reset is held
  assign issue = !reset && (state_q == FETCH) && (count < DEPTH_C) && !bus.redirect_valid;
  assign push  = (state_q == WAIT_RSP) && bus.imem_rvalid && (tag_q == epoch_q) && !bus.redirect_valid;
  assign push_data = '{pc: issued_pc_q, instr: bus.imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.instr_ready),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    epoch_d     = epoch_q;
    tag_d       = tag_q;
`ifdef MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      FETCH: begin
        if (issue) begin
          pc_d        = pc_q + 32'(INSTR_BYTES);
          issued_pc_d = pc_q;
          tag_d       = epoch_q;
          state_d     = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.imem_rvalid) begin
          state_d = FETCH;
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // A redirect still leaves WAIT_RSP alone; the epoch flip discards the old reply
    if (bus.redirect_valid) begin
      pc_d    = target_pc;
      epoch_d = ~epoch_q;
`ifdef MISALIGN_TRAP_EN
      if (target_misaligned) begin
        misaligned_d = 1'b1;
        state_d      = TRAP;
      end else begin
        misaligned_d = 1'b0;
        if (state_q == TRAP) begin
          state_d = FETCH;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
      epoch_q     <= 1'b0;
      tag_q       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      epoch_q     <= epoch_d;
      tag_q       <= tag_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q[ADDR_W+1:2];
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.opcode      = head.instr[6:0];
`ifdef MISALIGN_TRAP_EN
  assign bus.fetch_misaligned = misaligned_q;
`else
  assign bus.fetch_misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_queue : directed table/sequence bench for fetch_queue       |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;

  typedef struct {
    logic        ready;
    logic        req;
    logic [8:0]  addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  function automatic logic [31:0] mk(input logic [8:0] a);
    return {16'hBEEF ^ {7'd0, a}, a, a[6:0] ^ 7'h33};
  endfunction

  // Memory model: accept at posedge, answer mem_lat cycles later (visible from negedge)
  initial begin : mem_model
    logic       pend;
    int         cd;
    logic [8:0] maddr;
    pend = 1'b0;
    cd = 0;
    maddr = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        pend = 1'b0;
      end else if (bus.imem_req) begin
        pend  = 1'b1;
        cd    = mem_lat;
        maddr = bus.imem_addr;
      end
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      if (!reset && pend) begin
        cd = cd - 1;
        if (cd <= 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mk(maddr);
          pend            = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic check_head(input string name, input logic [31:0] pc);
    logic [31:0] w;
    w = mk(pc[10:2]);
    chk({name, "_valid"}, bus.instr_valid, 1'b1);
    chk({name, "_pc"}, bus.instr_pc, pc);
    chk({name, "_instr"}, bus.instr, w);
    chk({name, "_opcode"}, bus.opcode, w[6:0]);
  endtask

  // Leaves the bench 1 ns after the negedge where reset drops (cycle 0)
  task automatic do_reset(input int lat);
    mem_lat = lat;
    reset   = 1'b1;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  vec_t tbl[7];

  initial begin : stim
    int nreq;
    int pops;
    int bad_valid;
    logic [31:0] exp_pc;
    logic [31:0] p5[5];
    logic        r5[5];

    tbl[0] = '{1'b1, 1'b1, 9'd0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 9'd0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 9'd1, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 9'd0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 9'd2, 1'b1, 32'h4};
    tbl[5] = '{1'b1, 1'b0, 9'd0, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 9'd3, 1'b1, 32'h8};

    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset state while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    chk("rst_opcode", bus.opcode, 7'h0);
    chk("rst_misaligned", bus.fetch_misaligned, 1'b0);

    // Streaming with latency 1, decode always ready
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cyc();
      drive(tbl[i].ready, 1'b0, 32'h0);
      chk($sformatf("stream%0d_req", i), bus.imem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("stream%0d_addr", i), bus.imem_addr, tbl[i].addr);
      if (tbl[i].valid) check_head($sformatf("stream%0d", i), tbl[i].pc);
      else chk($sformatf("stream%0d_valid", i), bus.instr_valid, 1'b0);
    end

    // Back-pressure: queue fills to DEPTH then fetching stops
    do_reset(1);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) cyc();
      drive(1'b0, 1'b0, 32'h0);
      if (bus.imem_req) nreq++;
    end
    chk("bp_req_count", nreq, 4);
    chk("bp_req_idle", bus.imem_req, 1'b0);
    p5 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    r5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cyc();
      drive(1'b1, 1'b0, 32'h0);
      check_head($sformatf("bp_drain%0d", i), p5[i]);
      chk($sformatf("bp_drain%0d_req", i), bus.imem_req, r5[i]);
      if (i == 1) chk("bp_resume_addr", bus.imem_addr, 9'd4);
    end

    // Redirect while a latency-3 response is outstanding
    do_reset(3);
    drive(1'b1, 1'b0, 32'h0);
    chk("rdo_req0", bus.imem_req, 1'b1);
    cyc();
    drive(1'b1, 1'b1, 32'h100);
    chk("rdo_valid1", bus.instr_valid, 1'b0);
    for (int i = 2; i < 4; i++) begin
      cyc();
      drive(1'b1, 1'b0, 32'h0);
      chk($sformatf("rdo_req%0d", i), bus.imem_req, 1'b0);
      chk($sformatf("rdo_valid%0d", i), bus.instr_valid, 1'b0);
    end
    cyc();
    chk("rdo_req4", bus.imem_req, 1'b1);
    chk("rdo_addr4", bus.imem_addr, 9'h40);
    for (int i = 5; i < 8; i++) begin
      cyc();
      chk($sformatf("rdo_valid%0d", i), bus.instr_valid, 1'b0);
    end
    cyc();
    check_head("rdo_first", 32'h100);

    // Redirect coinciding with rvalid and a pop
    do_reset(1);
    drive(1'b0, 1'b0, 32'h0);
    repeat (3) cyc();
    chk("rsame_rvalid_seen", bus.imem_rvalid, 1'b1);
    check_head("rsame_before", 32'h0);
    drive(1'b1, 1'b1, 32'h100);
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    chk("rsame_valid_after", bus.instr_valid, 1'b0);
    chk("rsame_req_after", bus.imem_req, 1'b1);
    chk("rsame_addr_after", bus.imem_addr, 9'h40);
    repeat (2) cyc();
    check_head("rsame_first", 32'h100);

    // Push+pop at count=DEPTH-1 across many pointer wraps
    do_reset(1);
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 1; i < 7; i++) begin
      cyc();
      drive(1'b0, 1'b0, 32'h0);
    end
    pops = 0;
    bad_valid = 0;
    exp_pc = 32'h0;
    for (int k = 0; k < 120 && pops < 20; k++) begin
      cyc();
      drive(bus.imem_rvalid, 1'b0, 32'h0);
      if (!bus.instr_valid) bad_valid++;
      if (bus.instr_ready) begin
        chk($sformatf("wrap_pc%0d", pops), bus.instr_pc, exp_pc);
        exp_pc = exp_pc + 32'h4;
        pops++;
      end
    end
    chk("wrap_pop_count", pops, 20);
    chk("wrap_never_empty", bad_valid, 0);

    // pc wraps modulo 2^32
    do_reset(1);
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("pcwrap_req_on_redirect", bus.imem_req, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    chk("pcwrap_addr_top", bus.imem_addr, 9'h1FF);
    repeat (2) cyc();
    check_head("pcwrap_head", 32'hFFFF_FFFC);
    chk("pcwrap_req_next", bus.imem_req, 1'b1);
    chk("pcwrap_addr_zero", bus.imem_addr, 9'h000);

    // Misaligned redirect target
    do_reset(1);
    drive(1'b1, 1'b1, 32'h102);
    cyc();
    drive(1'b1, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", bus.fetch_misaligned, 1'b1);
    chk("mis_req1", bus.imem_req, 1'b0);
    cyc();
    chk("mis_req2", bus.imem_req, 1'b0);
    drive(1'b1, 1'b1, 32'h200);
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    chk("mis_flag_clear", bus.fetch_misaligned, 1'b0);
    chk("mis_req_resume", bus.imem_req, 1'b1);
    chk("mis_addr_resume", bus.imem_addr, 9'h080);
    repeat (2) cyc();
    check_head("mis_first", 32'h200);
`else
    chk("mis_flag_tied", bus.fetch_misaligned, 1'b0);
    chk("mis_req1", bus.imem_req, 1'b1);
    chk("mis_addr_forced", bus.imem_addr, 9'h040);
    repeat (2) cyc();
    check_head("mis_first", 32'h100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
